mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ACK_TO, default 255: maximum cycles to wait for sm_ack before aborting (range 1..65535).
REQ-002 SHALL take widths from cpu_params_pkg (PC_SZ, CL_SZ, CL_LEN) and the ARB_Data type {rw, rw_addr, wr_data} from cpu_structs_pkg.
REQ-003 SHALL have port clk_in, input, 1: the single clock.
REQ-004 SHALL have port reset_in, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports ic_req (in, 1), ic_req_data (in, ARB_Data), ic_ack (out, 1), ic_err (out, 1), ic_rd_data (out, CL_LEN*8): L1 I$ requester.
REQ-006 SHALL have ports dc_req (in, 1), dc_req_data (in, ARB_Data), dc_ack (out, 1), dc_err (out, 1), dc_rd_data (out, CL_LEN*8): L1 D$ requester.
REQ-007 SHALL have ports sm_req (out, 1), sm_req_data (out, ARB_Data), sm_ack (in, 1), sm_rd_data (in, CL_LEN*8): system memory side.
REQ-008 SHALL have port owner, output, 1: 0 = I$, 1 = D$; valid while sm_req=1.

Function
REQ-009 SHALL implement the states IDLE, MEM, RESP.
REQ-010 IDLE: if any req=1, select a winner per REQ-016/017, latch its ARB_Data and owner, and go to MEM. Otherwise stay in IDLE.
REQ-011 MEM: drive sm_req=1 with the latched data, so sm_req rises the cycle after the grant. Latency from req to sm_req is 1 cycle.
REQ-012 sm_req_data SHALL remain stable until sm_ack or timeout.
REQ-013 MEM, when sm_ack=1: if rw=1, register sm_rd_data into the owner's rd_data. Go to RESP.
REQ-014 RESP: pulse the owner's ack for exactly 1 cycle, then return to IDLE.
- The non-owner's ack SHALL stay 0.
- Requester req sampled during RESP SHALL be ignored.
- The requester drops req on the edge where it sees ack=1.
REQ-015 For writes (rw=0), rd_data SHALL hold its previous value.
REQ-016 With ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that did not win the last grant.
REQ-017 Without ARB_RR_EN, simultaneous requests SHALL always be granted to the D$.
REQ-018 A lone requester SHALL be granted in the first IDLE cycle in which it is sampled, regardless of arbitration mode.
REQ-019 A wait counter SHALL clear on entry to MEM and increment each MEM cycle without sm_ack.
- When it reaches ACK_TO: drop sm_req, go to RESP, and pulse the owner's ack and err together.
- rd_data SHALL be unchanged on timeout.
REQ-020 If sm_ack arrives in the same cycle the counter reaches ACK_TO, the cycle SHALL count as success (err=0).
REQ-021 err SHALL be 1 only in the RESP cycle of an aborted transfer.
REQ-022 The minimum transaction is 3 cycles (IDLE, MEM with sm_ack, RESP). Back-to-back grants SHALL be possible every 3 cycles.

Reset
REQ-023 When reset_in=1 at a clk_in edge, the block SHALL enter IDLE.
- sm_req, ic_ack, dc_ack, ic_err, dc_err and owner SHALL be 0.
- sm_req_data, ic_rd_data and dc_rd_data SHALL be 0.
- Wait counter SHALL be 0.
- Last-grant SHALL be I$, so the first simultaneous request goes to the D$.
REQ-024 Reset in MEM or RESP SHALL abandon the transfer with no ack pulse. sm_req SHALL be 0 the cycle after reset.

Configuration
REQ-025 Macro ARB_RR_EN defined: round-robin per REQ-016, using a 1-bit last-grant register updated on every grant.
REQ-026 Macro ARB_RR_EN undefined: fixed D$ priority per REQ-017, and no last-grant register SHALL exist.

Structure
REQ-027 The ARB_STATE enum (IDLE, MEM, RESP) SHALL live in cpu_structs_pkg. ARB_Data SHALL be reused unchanged.
REQ-028 The winner-select logic SHALL be a sub-module arb_sel: inputs ic_req, dc_req, last; output gnt. It contains the ARB_RR_EN conditional.
REQ-029 The FSM, data latches, timeout counter and response registers SHALL be in mem_arb.

Verification
REQ-030 I$ read only: ic_req with rw=1, rw_addr=0x10; sm_ack at 3rd MEM cycle, sm_rd_data=0xA5.. -> sm_req rises 1 cycle after ic_req; ic_ack=1 for 1 cycle with ic_rd_data=0xA5..; dc_ack=0.
REQ-031 Simultaneous ic_req and dc_req held for 4 transactions, sm_ack immediate -> owner sequence D,I,D,I with ARB_RR_EN; D,D,D,D without (I$ waits until dc_req drops).
REQ-032 D$ write rw=0, wr_data=0x1234.., sm_ack after 1 cycle -> sm_req_data.wr_data=0x1234.. held until ack; dc_ack pulses; dc_rd_data unchanged.
REQ-033 ACK_TO=4, sm_ack never asserted -> sm_req high for exactly 4 cycles; owner ack and err pulse together; next request is granted normally.
REQ-034 reset_in asserted during MEM -> next cycle sm_req=0, all outputs 0, no ack; a new ic_req after reset completes normally.
REQ-035 sm_ack coincident with the timeout cycle (ACK_TO=4, ack in 4th MEM cycle) -> ack with err=0 and rd_data updated.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - address and cache-line sizing shared by the memory path
package cpu_params_pkg;
  localparam int PC_SZ  = 32;
  localparam int CL_SZ  = 4;   // log2 of the line size in bytes
  localparam int CL_LEN = 16;  // bytes per cache line
endpackage

// File: rtl/cpu_structs_pkg.sv
// rtl/cpu_structs_pkg.sv - request payload and arbiter state types for the memory path
package cpu_structs_pkg;
  import cpu_params_pkg::*;

  typedef struct packed {
    logic                      rw;       // 1 = line read, 0 = line write
    logic [PC_SZ-CL_SZ-1:0]    rw_addr;  // line address
    logic [CL_LEN*8-1:0]       wr_data;
  } ARB_Data;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } ARB_STATE;
endpackage

// File: rtl/arb_sel.sv
// rtl/arb_sel.sv - I$/D$ winner select; ARB_RR_EN gives round-robin, otherwise D$ has fixed priority
// gnt: 0 = I$, 1 = D$; last is the previous winner (only meaningful with ARB_RR_EN)
module arb_sel (
  input  logic ic_req,
  input  logic dc_req,
  input  logic last,
  output logic gnt
);
`ifdef ARB_RR_EN
  // On contention hand the grant to whoever lost last time
  assign gnt = !ic_req || (dc_req && !last);
`else
  logic w_unused_last;
  assign w_unused_last = last;
  assign gnt = !ic_req || dc_req;
`endif
endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - arbitrates I$ and D$ line requests onto one system memory port with ack timeout
// ARB_RR_EN selects round-robin arbitration (adds a last-grant register); undefined gives D$ priority
module mem_arb
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int unsigned ACK_TO = 255
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                ic_req,
  input  ARB_Data             ic_req_data,
  output logic                ic_ack,
  output logic                ic_err,
  output logic [CL_LEN*8-1:0] ic_rd_data,
  input  logic                dc_req,
  input  ARB_Data             dc_req_data,
  output logic                dc_ack,
  output logic                dc_err,
  output logic [CL_LEN*8-1:0] dc_rd_data,
  output logic                sm_req,
  output ARB_Data             sm_req_data,
  input  logic                sm_ack,
  input  logic [CL_LEN*8-1:0] sm_rd_data,
  output logic                owner
);
  localparam int CNT_W = 16;

  ARB_STATE            r_state;
  ARB_STATE            w_next;
  ARB_Data             r_req_data;
  logic                r_owner;
  logic [CNT_W-1:0]    r_wait;
  logic                r_ic_ack;
  logic                r_dc_ack;
  logic                r_ic_err;
  logic                r_dc_err;
  logic [CL_LEN*8-1:0] r_ic_rd;
  logic [CL_LEN*8-1:0] r_dc_rd;
  logic                w_gnt;
  logic                w_last;
  logic                w_grant;
  logic                w_ack_ok;
  logic                w_timeout;

  arb_sel u_sel (
    .ic_req (ic_req),
    .dc_req (dc_req),
    .last   (w_last),
    .gnt    (w_gnt)
  );

  assign w_grant   = (r_state == IDLE) && (ic_req || dc_req);
  assign w_ack_ok  = (r_state == MEM) && sm_ack;
  // An ack arriving on the final allowed cycle wins over the abort
  assign w_timeout = (r_state == MEM) && !sm_ack && (r_wait == CNT_W'(ACK_TO - 1));

`ifdef ARB_RR_EN
  logic r_last;
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_last <= 1'b0;
    end else if (w_grant) begin
      r_last <= w_gnt;
    end
  end
  assign w_last = r_last;
`else
  assign w_last = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ic_req || dc_req) w_next = MEM;
      MEM:     if (w_ack_ok || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_owner    <= 1'b0;
      r_req_data <= '0;
      r_wait     <= '0;
      r_ic_ack   <= 1'b0;
      r_dc_ack   <= 1'b0;
      r_ic_err   <= 1'b0;
      r_dc_err   <= 1'b0;
      r_ic_rd    <= '0;
      r_dc_rd    <= '0;
    end else begin
      r_ic_ack <= 1'b0;
      r_dc_ack <= 1'b0;
      r_ic_err <= 1'b0;
      r_dc_err <= 1'b0;
      if (w_grant) begin
        r_owner    <= w_gnt;
        r_req_data <= w_gnt ? dc_req_data : ic_req_data;
        r_wait     <= '0;
      end
      if (w_ack_ok && r_req_data.rw) begin
        if (r_owner) begin
          r_dc_rd <= sm_rd_data;
        end else begin
          r_ic_rd <= sm_rd_data;
        end
      end
      if ((r_state == MEM) && !w_ack_ok && !w_timeout) begin
        r_wait <= r_wait + CNT_W'(1);
      end
      // Ack/err registers are high exactly for the RESP cycle
      if (w_ack_ok || w_timeout) begin
        r_ic_ack <= !r_owner;
        r_dc_ack <= r_owner;
        r_ic_err <= w_timeout && !r_owner;
        r_dc_err <= w_timeout && r_owner;
      end
    end
  end

  assign sm_req      = (r_state == MEM);
  assign sm_req_data = r_req_data;
  assign owner       = r_owner;
  assign ic_ack      = r_ic_ack;
  assign dc_ack      = r_dc_ack;
  assign ic_err      = r_ic_err;
  assign dc_err      = r_dc_err;
  assign ic_rd_data  = r_ic_rd;
  assign dc_rd_data  = r_dc_rd;
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - randomized self-checking bench for mem_arb against a transaction-level schedule model
module tb_mem_arb;
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  localparam int ACK_TO = 4;
  localparam int DW     = CL_LEN * 8;
  localparam int AW     = PC_SZ - CL_SZ;

  logic          clk_in      = 1'b0;
  logic          reset_in    = 1'b1;
  logic          ic_req      = 1'b0;
  logic          dc_req      = 1'b0;
  logic          sm_ack      = 1'b0;
  ARB_Data       ic_req_data = '0;
  ARB_Data       dc_req_data = '0;
  logic [DW-1:0] sm_rd_data  = '0;
  logic          ic_ack, ic_err, dc_ack, dc_err, sm_req, owner;
  ARB_Data       sm_req_data;
  logic [DW-1:0] ic_rd_data, dc_rd_data;

  mem_arb #(.ACK_TO(ACK_TO)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .ic_req      (ic_req),
    .ic_req_data (ic_req_data),
    .ic_ack      (ic_ack),
    .ic_err      (ic_err),
    .ic_rd_data  (ic_rd_data),
    .dc_req      (dc_req),
    .dc_req_data (dc_req_data),
    .dc_ack      (dc_ack),
    .dc_err      (dc_err),
    .dc_rd_data  (dc_rd_data),
    .sm_req      (sm_req),
    .sm_req_data (sm_req_data),
    .sm_ack      (sm_ack),
    .sm_rd_data  (sm_rd_data),
    .owner       (owner)
  );

  always #5 clk_in = ~clk_in;

  // One expected cycle: kind 0 = idle, 1 = memory request outstanding, 2 = response pulse
  typedef struct {
    int            kind;
    bit            own;
    ARB_Data       data;
    bit            ack_now;
    logic [DW-1:0] rdv;
    bit            err;
  } rec_t;

  rec_t          sched[$];
  bit            own_log[$];
  int            checks = 0;
  int            errors = 0;
  bit            ic_pend = 0, dc_pend = 0;
  ARB_Data       ic_txn = '0, dc_txn = '0;
  int            p_ic = 0, p_dc = 0;
  int            forced_lat = 0;
  bit            forced_rd_en = 0;
  logic [DW-1:0] forced_rd = '0;
  bit            m_last = 0;
  logic [DW-1:0] exp_ic_rd = '0, exp_dc_rd = '0;
  bit            fresh = 1;
  int            smreq_cnt = 0, ack_cnt = 0, err_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic ARB_Data rand_txn();
    ARB_Data t;
    t.rw      = 1'($urandom_range(0, 1));
    t.rw_addr = AW'($urandom);
    t.wr_data = rand_line();
    return t;
  endfunction

  task automatic compare(input rec_t cur);
    chk("sm_req", DW'(sm_req), DW'(cur.kind == 1));
    chk("ic_ack", DW'(ic_ack), DW'(cur.kind == 2 && !cur.own));
    chk("dc_ack", DW'(dc_ack), DW'(cur.kind == 2 && cur.own));
    chk("ic_err", DW'(ic_err), DW'(cur.kind == 2 && !cur.own && cur.err));
    chk("dc_err", DW'(dc_err), DW'(cur.kind == 2 && cur.own && cur.err));
    chk("ic_rd_data", ic_rd_data, exp_ic_rd);
    chk("dc_rd_data", dc_rd_data, exp_dc_rd);
    if (cur.kind == 1) begin
      chk("owner", DW'(owner), DW'(cur.own));
      chk("sm_rw", DW'(sm_req_data.rw), DW'(cur.data.rw));
      chk("sm_addr", DW'(sm_req_data.rw_addr), DW'(cur.data.rw_addr));
      chk("sm_wr_data", sm_req_data.wr_data, cur.data.wr_data);
    end
    if (fresh) begin
      chk("rst_owner", DW'(owner), DW'(0));
      chk("rst_sm_addr", DW'(sm_req_data.rw_addr), DW'(0));
      chk("rst_sm_wr_data", sm_req_data.wr_data, '0);
    end
  endtask

  // Arbitration decision plus the full expected timeline of the granted transfer
  task automatic grant();
    bit            w;
    int            lat, nm;
    ARB_Data       d;
    logic [DW-1:0] rv;
    rec_t          r;
    if (ic_pend && dc_pend) begin
`ifdef ARB_RR_EN
      w = ~m_last;
`else
      w = 1'b1;
`endif
    end else begin
      w = dc_pend;
    end
    m_last = w;
    own_log.push_back(w);
    fresh = 0;
    d   = w ? dc_txn : ic_txn;
    lat = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, ACK_TO + 2));
    rv  = forced_rd_en ? forced_rd : rand_line();
    nm  = (lat < ACK_TO) ? lat : ACK_TO;
    for (int i = 1; i <= nm; i++) begin
      r.kind = 1; r.own = w; r.data = d; r.ack_now = (i == lat); r.rdv = rv; r.err = 0;
      sched.push_back(r);
    end
    r.kind = 2; r.own = w; r.data = d; r.ack_now = 0; r.rdv = rv; r.err = (lat > ACK_TO);
    sched.push_back(r);
  endtask

  task automatic step(input bit do_rst);
    rec_t cur;
    bit   idle;
    @(negedge clk_in);
    idle = (sched.size() == 0);
    if (idle) begin
      cur.kind = 0; cur.own = 0; cur.data = '0; cur.ack_now = 0; cur.rdv = '0; cur.err = 0;
    end else begin
      cur = sched.pop_front();
    end
    compare(cur);
    if (cur.kind == 1) smreq_cnt++;
    if (cur.kind == 2) begin
      ack_cnt++;
      if (cur.err) err_cnt++;
      if (cur.own) dc_pend = 0; else ic_pend = 0;
    end
    if (!do_rst && cur.kind == 1 && cur.ack_now && cur.data.rw) begin
      if (cur.own) exp_dc_rd = cur.rdv; else exp_ic_rd = cur.rdv;
    end
    if (!ic_pend && int'($urandom_range(1, 100)) <= p_ic) begin ic_pend = 1; ic_txn = rand_txn(); end
    if (!dc_pend && int'($urandom_range(1, 100)) <= p_dc) begin dc_pend = 1; dc_txn = rand_txn(); end
    ic_req      = ic_pend;
    ic_req_data = ic_txn;
    dc_req      = dc_pend;
    dc_req_data = dc_txn;
    sm_ack      = !do_rst && cur.kind == 1 && cur.ack_now;
    sm_rd_data  = sm_ack ? cur.rdv : rand_line();
    reset_in    = do_rst;
    if (do_rst) begin
      sched.delete();
      exp_ic_rd = '0;
      exp_dc_rd = '0;
      m_last    = 0;
      fresh     = 1;
    end else if (idle && (ic_pend || dc_pend)) begin
      grant();
    end
  endtask

  task automatic run_txn(input int max_steps, output int n);
    int a0;
    a0 = ack_cnt;
    n  = 0;
    while (ack_cnt == a0 && n < max_steps) begin
      step(0);
      n++;
    end
    checks++;
    if (ack_cnt == a0) begin
      errors++;
      $display("FAIL wait_ack actual=no_ack required=ack_within_%0d_cycles", max_steps);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, s0, e0, base, k;
    logic [3:0] seq;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_sm_req", DW'(sm_req), DW'(0));
    chk("rst_ic_ack", DW'(ic_ack), DW'(0));
    chk("rst_dc_ack", DW'(dc_ack), DW'(0));
    chk("rst_ic_rd", ic_rd_data, '0);

    // I$ read, ack on the third memory cycle
    forced_lat = 3; forced_rd_en = 1; forced_rd = {CL_LEN{8'hA5}};
    ic_txn = '0; ic_txn.rw = 1'b1; ic_txn.rw_addr = AW'(32'h10); ic_pend = 1;
    s0 = smreq_cnt;
    run_txn(20, n);
    chk("a_cycles", DW'(n), DW'(5));
    chk("a_smreq_cycles", DW'(smreq_cnt - s0), DW'(3));
    chk("a_ic_rd", ic_rd_data, {CL_LEN{8'hA5}});
    chk("a_dc_ack", DW'(dc_ack), DW'(0));

    // D$ read to seed dc_rd_data, then a D$ write that must leave it alone
    forced_lat = 1; forced_rd = {CL_LEN{8'h5A}};
    dc_txn = '0; dc_txn.rw = 1'b1; dc_txn.rw_addr = AW'(32'h40); dc_pend = 1;
    run_txn(20, n);
    chk("b_read_cycles", DW'(n), DW'(3));
    forced_lat = 2;
    dc_txn = '0; dc_txn.rw = 1'b0; dc_txn.rw_addr = AW'(32'h20); dc_txn.wr_data = {(DW/16){16'h1234}};
    dc_pend = 1;
    run_txn(20, n);
    chk("b_write_cycles", DW'(n), DW'(4));
    chk("b_dc_rd_kept", dc_rd_data, {CL_LEN{8'h5A}});

    // No ack at all: abort after ACK_TO cycles, then a normal transfer
    forced_lat = 99;
    ic_txn = '0; ic_txn.rw = 1'b1; ic_pend = 1;
    s0 = smreq_cnt; e0 = err_cnt;
    run_txn(20, n);
    chk("c_cycles", DW'(n), DW'(6));
    chk("c_smreq_cycles", DW'(smreq_cnt - s0), DW'(4));
    chk("c_err_count", DW'(err_cnt - e0), DW'(1));
    chk("c_ic_err", DW'(ic_err), DW'(1));
    chk("c_ic_rd_kept", ic_rd_data, {CL_LEN{8'hA5}});
    forced_lat = 1;
    dc_txn = rand_txn(); dc_pend = 1; e0 = err_cnt;
    run_txn(20, n);
    chk("c_next_cycles", DW'(n), DW'(3));
    chk("c_next_no_err", DW'(err_cnt - e0), DW'(0));

    // Ack on the same cycle the timeout would fire
    forced_lat = 4; forced_rd = {CL_LEN{8'hC3}};
    ic_txn = '0; ic_txn.rw = 1'b1; ic_pend = 1; e0 = err_cnt;
    run_txn(20, n);
    chk("d_cycles", DW'(n), DW'(6));
    chk("d_no_err", DW'(err_cnt - e0), DW'(0));
    chk("d_ic_err", DW'(ic_err), DW'(0));
    chk("d_ic_rd", ic_rd_data, {CL_LEN{8'hC3}});

    // Reset while the transfer is in progress; requester keeps asking and is served after
    forced_lat = 3;
    ic_txn = rand_txn(); ic_txn.rw = 1'b1; ic_pend = 1; e0 = ack_cnt;
    step(0); step(0); step(1); step(0);
    chk("e_no_ack", DW'(ack_cnt - e0), DW'(0));
    chk("e_sm_req", DW'(sm_req), DW'(0));
    chk("e_ic_rd_cleared", ic_rd_data, '0);
    run_txn(20, n);
    chk("e_after_cycles", DW'(n), DW'(4));

    // Both requesters held continuously for four back-to-back transfers
    step(1);
    forced_lat = 1; forced_rd_en = 0;
    p_ic = 100; p_dc = 100;
    ic_pend = 1; ic_txn = rand_txn(); dc_pend = 1; dc_txn = rand_txn();
    base = own_log.size();
    for (int i = 0; i < 4; i++) begin
      run_txn(20, n);
      chk("f_cycles", DW'(n), DW'(3));
    end
    p_ic = 0; p_dc = 0;
    for (int i = 0; i < 4; i++) seq[i] = own_log[base + i];
`ifdef ARB_RR_EN
    chk("f_owner_seq", DW'(seq), DW'(4'b0101));
`else
    chk("f_owner_seq", DW'(seq), DW'(4'b1111));
`endif
    k = 0;
    while ((ic_pend || dc_pend || sched.size() > 0) && k < 40) begin step(0); k++; end

    // Random traffic with random latencies and occasional resets
    forced_lat = 0;
    p_ic = 25; p_dc = 25;
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0);
    p_ic = 0; p_dc = 0;
    k = 0;
    while ((ic_pend || dc_pend || sched.size() > 0) && k < 40) begin step(0); k++; end
    checks++;
    if (ic_pend || dc_pend || sched.size() > 0) begin
      errors++;
      $display("FAIL drain actual=busy required=idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
